unibus_slave_handshake: RTL

Slave-side Unibus MSYN/SSYN handshake responder for device register blocks: detects a master's MSYN assertion, waits the bus deskew interval, latches address/control/data, hands one request to the local device, and returns SSYN. It sits between the bus pad interface and each device's register file. It is the receiving end of the master-side delay and pulse timing chain, at a 50 MHz system clock.

---
 rtl/unibus_pkg.sv | 19 +
 rtl/unibus_slave_handshake_sync_rise_det.sv | 36 +++
 rtl/unibus_slave_handshake.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/unibus_pkg.sv
// Purpose: shared types and constants for the Unibus slave handshake block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package unibus_pkg;

  localparam int DESKEW_TICKS  = 5;   // 100 ns at 50 MHz
  localparam int HOLD_TICKS    = 3;   // 60 ns at 50 MHz
  localparam int UNIBUS_ADDR_W = 18;
  localparam int UNIBUS_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DESKEW,
    ST_REQ,
    ST_SSYN,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/unibus_slave_handshake_sync_rise_det.sv
// Purpose: rising-edge detector on a level signal, gated until two clean cycles after reset.
// Latency: rise_o is combinational from sig_i against the registered previous sample.
// Backpressure: none; a level already high when reset releases never produces a rise.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   sig_i      : level input to watch
//   rise_o     : high for the cycle where sig_i is high and was low the cycle before (once armed)
module sync_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic       sig_q;
  logic [1:0] arm_cnt_q;
  logic [1:0] arm_cnt_d;
  logic       armed;

  // arm_cnt saturates at 2; by then sig_q holds a genuine post-reset sample.
  assign armed     = arm_cnt_q[1];
  assign arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
  assign rise_o    = sig_i & ~sig_q & armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q     <= 1'b0;
      arm_cnt_q <= 2'd0;
    end else begin
      sig_q     <= sig_i;
      arm_cnt_q <= arm_cnt_d;
    end
  end

endmodule

// File: rtl/unibus_slave_handshake.sv
// Purpose: Unibus slave MSYN/SSYN responder; deskews, latches the bus cycle, hands one request to the device, returns SSYN.
// Latency: MSYN rise to dev_req DESKEW+1 cycles; dev_ack to SSYN 1 cycle; MSYN fall to driver release HOLD+1 cycles.
// Backpressure: dev_req is held until dev_ack; SSYN is held until the master drops MSYN.
//
// Ports:
//   bus_msyn/bus_addr/bus_c1/bus_c0/bus_din/addr_match : master side inputs
//   bus_ssyn/bus_dout/bus_dout_en                       : slave response to the bus
//   dev_req/dev_addr/dev_wr/dev_byte/dev_wdata          : request to the local register file
//   dev_ack/dev_rdata                                   : device completion and read data
module unibus_slave_handshake
  import unibus_pkg::*;
#(
  parameter int ADDR_W = UNIBUS_ADDR_W,
  parameter int DESKEW = DESKEW_TICKS,
  parameter int HOLD   = HOLD_TICKS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bus_msyn,
  input  logic [ADDR_W-1:0]        bus_addr,
  input  logic                     bus_c1,
  input  logic                     bus_c0,
  input  logic [UNIBUS_DATA_W-1:0] bus_din,
  input  logic                     addr_match,
  output logic                     bus_ssyn,
  output logic [UNIBUS_DATA_W-1:0] bus_dout,
  output logic                     bus_dout_en,
  output logic                     dev_req,
  output logic [ADDR_W-1:0]        dev_addr,
  output logic                     dev_wr,
  output logic                     dev_byte,
  output logic [UNIBUS_DATA_W-1:0] dev_wdata,
  input  logic                     dev_ack,
  input  logic [UNIBUS_DATA_W-1:0] dev_rdata
);

  localparam int CNT_MAX = (DESKEW > HOLD) ? DESKEW : HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       ssyn_q, ssyn_d;
  logic [UNIBUS_DATA_W-1:0]   dout_q, dout_d;
  logic                       dout_en_q, dout_en_d;
  logic                       req_q, req_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic                       wr_q, wr_d;
  logic                       byte_q, byte_d;
  logic [UNIBUS_DATA_W-1:0]   wdata_q, wdata_d;
  logic                       start;

  sync_rise_det u_msyn_rise (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (bus_msyn),
    .rise_o (start)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ssyn_d    = ssyn_q;
    dout_d    = dout_q;
    dout_en_d = dout_en_q;
    req_d     = req_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    byte_d    = byte_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DESKEW;
          cnt_d   = CNT_W'(1);
        end
      end

      ST_DESKEW: begin
        if (!bus_msyn) begin
          // Master withdrew before the lines settled: drop it silently.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DESKEW)) begin
          // Lines have been stable for the full deskew window; capture them
          // even when the decode misses so dev_* reflects the last bus cycle.
          addr_d  = bus_addr;
          wr_d    = bus_c1;
          byte_d  = bus_c0;
          wdata_d = bus_din;
          cnt_d   = '0;
          if (addr_match) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_REQ: begin
        // The device transaction always runs to completion, whatever MSYN does.
        if (dev_ack) begin
          req_d = 1'b0;
          if (!wr_q) begin
            dout_d    = dev_rdata;
            dout_en_d = 1'b1;
          end
          if (bus_msyn) begin
            state_d = ST_SSYN;
            ssyn_d  = 1'b1;
          end else begin
            // Master already gone: no SSYN, just release the data drivers later.
            state_d = ST_HOLD;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      ST_SSYN: begin
        if (!bus_msyn) begin
          state_d = ST_HOLD;
          ssyn_d  = 1'b0;
          cnt_d   = CNT_W'(1);
        end
      end

      ST_HOLD: begin
        // MSYN is ignored here; a new cycle needs a fresh rise seen in IDLE.
        if (cnt_q == CNT_W'(HOLD)) begin
          dout_en_d = 1'b0;
          dout_d    = '0;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ssyn_q    <= 1'b0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      byte_q    <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ssyn_q    <= ssyn_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      byte_q    <= byte_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus_ssyn    = ssyn_q;
  assign bus_dout    = dout_q;
  assign bus_dout_en = dout_en_q;
  assign dev_req     = req_q;
  assign dev_addr    = addr_q;
  assign dev_wr      = wr_q;
  assign dev_byte    = byte_q;
  assign dev_wdata   = wdata_q;

endmodule
